ram_mc_arbiter: RTL and testbench

Parametrised successor to the single-port scratch memory: a word-addressed on-chip RAM shared by NUM_CH requesters (DMA/conv engines) through a round-robin arbiter. Memory is zeroed by a sequential clear sweep after reset instead of an in-cycle loop. Completion is signalled as per-channel single-cycle done pulses. One access per clock total, result registered.

---
 rtl/ram_mc_arbiter_if.sv | 28 ++
 rtl/ram_mc_arbiter.sv | 155 +++++++++++++++
 tb/tb_ram_mc_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_mc_arbiter_if.sv
// Request/response bundle between NUM_CH requesters and the shared RAM arbiter.
// master = requester side, slave = RAM side.
interface ram_mc_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH-1:0]        we;
  logic [NUM_CH*ADDR_W-1:0] addr;
  logic [NUM_CH*DATA_W-1:0] wdata;
  logic [DATA_W-1:0]        rdata;
  logic [NUM_CH-1:0]        grant;
  logic [NUM_CH-1:0]        done_read;
  logic [NUM_CH-1:0]        done_write;
  logic                     busy;
  logic                     err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, grant, done_read, done_write, busy, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, grant, done_read, done_write, busy, err
  );
endinterface

// File: rtl/ram_mc_arbiter.sv
// Word RAM shared by NUM_CH channels via round-robin arbitration, zeroed by a sweep after reset.
// Define RAM_BOUNDS_CHECK_EN to reject addresses >= DEPTH (err pulse) instead of wrapping them.
//
// state | meaning
// CLEAR | writing zero to one word per cycle, requests ignored, busy=1
// SERVE | one arbitrated access per cycle, results pulsed the next cycle
module ram_mc_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 32768,
  parameter int NUM_CH = 4
) (
  input logic             clk,
  input logic             RST,
  ram_mc_arbiter_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  typedef enum logic {CLEAR, SERVE} state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]  clr_cnt;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   win;
  logic              win_valid;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] win_onehot;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_we;
  logic              in_range;
  logic              go;
  logic              clr_we;

  logic [DATA_W-1:0] rdata_q;
  logic [NUM_CH-1:0] grant_q;
  logic [NUM_CH-1:0] done_read_q;
  logic [NUM_CH-1:0] done_write_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  // Last cycle's grant is excluded so a requester releasing req on its done pulse is never served twice.
  assign eligible = bus.req & ~grant_q;

  always_comb begin : arbitrate
    logic [CH_W-1:0] cand;
    win_valid = 1'b0;
    win       = '0;
    cand      = '0;
    for (int j = 1; j <= NUM_CH; j++) begin
      cand = CH_W'((int'(rr_ptr) + j) % NUM_CH);
      if (!win_valid && eligible[cand]) begin
        win_valid = 1'b1;
        win       = cand;
      end
    end
  end

  assign win_addr   = bus.addr[win*ADDR_W +: ADDR_W];
  assign win_wdata  = bus.wdata[win*DATA_W +: DATA_W];
  assign win_we     = bus.we[win];
  assign win_onehot = NUM_CH'(1) << win;

`ifdef RAM_BOUNDS_CHECK_EN
  assign in_range = ({1'b0, win_addr} < DEPTH_LIM);
`else
  assign in_range = 1'b1;
`endif

  // Address bits above the RAM index only matter for the bounds check.
  logic unused_addr_hi;
  assign unused_addr_hi = ^(win_addr >> IDX_W) ^ ^DEPTH_LIM;

  always_comb begin
    state_d = state_q;
    clr_we  = 1'b0;
    go      = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt == IDX_W'(DEPTH - 1)) begin
          state_d = SERVE;
        end
      end
      SERVE: begin
        go = win_valid;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      clr_cnt      <= '0;
      rr_ptr       <= CH_W'(NUM_CH - 1);
      rdata_q      <= '0;
      grant_q      <= '0;
      done_read_q  <= '0;
      done_write_q <= '0;
      err_q        <= 1'b0;
    end else begin
      grant_q      <= '0;
      done_read_q  <= '0;
      done_write_q <= '0;
      err_q        <= 1'b0;
      if (clr_we) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
      if (go) begin
        grant_q <= win_onehot;
        rr_ptr  <= win;
        err_q   <= ~in_range;
        if (win_we) begin
          done_write_q <= win_onehot;
        end else begin
          done_read_q <= win_onehot;
          if (in_range) begin
            rdata_q <= mem[win_addr[IDX_W-1:0]];
          end
        end
      end
    end
  end

  // Kept free of reset so the array maps onto plain RAM; the sweep does the clearing.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (go && win_we && in_range) begin
      mem[win_addr[IDX_W-1:0]] <= win_wdata;
    end
  end

  assign bus.rdata      = rdata_q;
  assign bus.grant      = grant_q;
  assign bus.done_read  = done_read_q;
  assign bus.done_write = done_write_q;
  assign bus.err        = err_q;
  assign bus.busy       = (state_q == CLEAR);

endmodule

// File: tb/tb_ram_mc_arbiter.sv
// Bench for ram_mc_arbiter (DEPTH=16, ADDR_W=5, 4 channels): directed vectors plus random traffic
// checked every cycle against a behavioural model of the shared RAM and its round-robin rules.
module tb_ram_mc_arbiter;
  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 16;
  localparam int NCH   = 4;
`ifdef RAM_BOUNDS_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_mc_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NCH)) bus ();

  ram_mc_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .NUM_CH(NCH)) dut (
    .clk(clk),
    .RST(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0] m_mem [DEPTH];
  int         m_clear = 0;
  int         m_last  = NCH - 1;
  logic [3:0] m_held  = '0;
  logic [7:0] m_rdata = '0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [3:0] grant;
    logic [3:0] dr;
    logic [3:0] dw;
    logic       err;
    logic [7:0] rdata;
  } vec_t;

  vec_t vt [13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] w, input logic [4:0] a, input logic [7:0] d);
    bus.req   = r;
    bus.we    = w;
    bus.addr  = {NCH{a}};
    bus.wdata = {NCH{d}};
  endtask

  // One clock: predict outputs from the model, advance, compare every output.
  task automatic tick();
    logic [3:0] eg, edr, edw;
    logic       ee, eb, inr;
    logic [7:0] er;
    logic [4:0] a;
    int         win, idx;
    eg = '0; edr = '0; edw = '0; ee = 1'b0; eb = 1'b0;
    if (rst) begin
      eb = 1'b1;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_clear = DEPTH;
      m_last  = NCH - 1;
      m_held  = '0;
      m_rdata = '0;
    end else if (m_clear > 0) begin
      m_clear--;
      eb = (m_clear > 0);
    end else begin
      win = -1;
      for (int j = 1; j <= NCH; j++) begin
        int c;
        c = (m_last + j) % NCH;
        if (win < 0 && bus.req[c] && !m_held[c]) win = c;
      end
      if (win >= 0) begin
        a   = bus.addr[win*AW +: AW];
        idx = int'(a) % DEPTH;
        inr = BCHK ? (int'(a) < DEPTH) : 1'b1;
        eg  = 4'b0001 << win;
        ee  = !inr;
        if (bus.we[win]) begin
          edw = eg;
          if (inr) m_mem[idx] = bus.wdata[win*DW +: DW];
        end else begin
          edr = eg;
          if (inr) m_rdata = m_mem[idx];
        end
        m_last = win;
      end
      m_held = eg;
    end
    er = m_rdata;
    @(posedge clk);
    #1;
    check("cycle", {10'b0, bus.busy, bus.err, bus.grant, bus.done_read, bus.done_write, bus.rdata},
                   {10'b0, eb, ee, eg, edr, edw, er});
  endtask

  initial begin
    int n;

    //       req    we     addr   wdata  grant  dr     dw     err    rdata
    vt[0]  = '{4'h0, 4'h0, 5'd0,  8'h00, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00};
    vt[1]  = '{4'h1, 4'h1, 5'd5,  8'hA5, 4'h1, 4'h0, 4'h1, 1'b0, 8'h00};
    vt[2]  = '{4'h2, 4'h0, 5'd5,  8'h00, 4'h2, 4'h2, 4'h0, 1'b0, 8'hA5};
    vt[3]  = '{4'h1, 4'h0, 5'd5,  8'h00, 4'h1, 4'h1, 4'h0, 1'b0, 8'hA5};
    vt[4]  = '{4'h4, 4'h4, 5'd9,  8'h3C, 4'h4, 4'h0, 4'h4, 1'b0, 8'hA5};
    vt[5]  = '{4'h8, 4'h8, 5'd9,  8'hC3, 4'h8, 4'h0, 4'h8, 1'b0, 8'hA5};
    vt[6]  = '{4'h4, 4'h0, 5'd9,  8'h00, 4'h4, 4'h4, 4'h0, 1'b0, 8'hC3};
    vt[7]  = '{4'h3, 4'h2, 5'd5,  8'h77, 4'h1, 4'h1, 4'h0, 1'b0, 8'hA5};
    vt[8]  = '{4'h3, 4'h2, 5'd5,  8'h77, 4'h2, 4'h0, 4'h2, 1'b0, 8'hA5};
    vt[9]  = '{4'h8, 4'h8, 5'd20, 8'h11, 4'h8, 4'h0, 4'h8, BCHK, 8'hA5};
    vt[10] = '{4'h2, 4'h0, 5'd4,  8'h00, 4'h2, 4'h2, 4'h0, 1'b0, BCHK ? 8'h00 : 8'h11};
    vt[11] = '{4'h1, 4'h0, 5'd5,  8'h00, 4'h1, 4'h1, 4'h0, 1'b0, 8'h77};
    vt[12] = '{4'h0, 4'h0, 5'd0,  8'h00, 4'h0, 4'h0, 4'h0, 1'b0, 8'h77};

    // Reset values
    rst = 1'b1;
    drive(4'h0, 4'h0, 5'd0, 8'h00);
    tick();
    tick();
    check("rst_busy", bus.busy, 1);
    check("rst_grant", bus.grant, 0);
    check("rst_done", {bus.done_read, bus.done_write, bus.err}, 0);
    check("rst_rdata", bus.rdata, 0);
    rst = 1'b0;
    repeat (DEPTH) tick();
    check("sweep1_end", bus.busy, 0);

    // Fill with garbage, then reset with every channel requesting
    for (int a = 0; a < DEPTH; a++) begin
      drive(4'b0001 << (a % NCH), 4'b0001 << (a % NCH), 5'(a), 8'(a * 37 + 5));
      tick();
      check("garbage_wr", bus.done_write, 4'b0001 << (a % NCH));
    end
    drive(4'hF, 4'h0, 5'd0, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("busy_len", n, DEPTH);

    // Round robin over continuous requests; each read walks the cleared words
    for (int i = 0; i < DEPTH; i++) begin
      drive(4'hF, 4'h0, 5'(i), 8'h00);
      tick();
      check("rr_grant", bus.grant, 4'b0001 << (i % NCH));
      check("clr_read", {bus.done_read, bus.rdata}, {4'b0001 << (i % NCH), 8'h00});
    end

    // Lone requester with req held high: served every other cycle
    drive(4'h0, 4'h0, 5'd0, 8'h00);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(4'b0100, 4'h0, 5'd0, 8'h00);
      tick();
      check("hold_dr2", bus.done_read[2], (i % 2 == 0) ? 1 : 0);
    end

    // Directed vectors
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].req, vt[i].we, vt[i].addr, vt[i].wdata);
      tick();
      check($sformatf("vec%0d", i),
            {11'b0, bus.grant, bus.done_read, bus.done_write, bus.err, bus.rdata},
            {11'b0, vt[i].grant, vt[i].dr, vt[i].dw, vt[i].err, vt[i].rdata});
    end

    // Reset arriving together with a write
    drive(4'b0010, 4'b0010, 5'd3, 8'h7E);
    rst = 1'b1;
    tick();
    check("rstmid_pulses", {bus.grant, bus.done_read, bus.done_write}, 0);
    check("rstmid_busy", bus.busy, 1);
    rst = 1'b0;
    drive(4'h0, 4'h0, 5'd0, 8'h00);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("rstmid_sweep", n, DEPTH);
    drive(4'b0010, 4'h0, 5'd3, 8'h00);
    tick();
    check("rstmid_rd", {bus.done_read, bus.rdata}, {4'b0010, 8'h00});

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      bus.req   = 4'($urandom);
      bus.we    = 4'($urandom);
      bus.addr  = 20'($urandom);
      bus.wdata = 32'($urandom);
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
